// File: rtl/axis_split_arbiter.sv
// Two-input round-robin AXI-Stream arbiter with a fully registered master port.
// Grants are held per packet (TLAST) or per burst of BURST_LEN beats.
module axis_split_arbiter #(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
  parameter string       ARB_MODE           = "PACKET",
  parameter int unsigned BURST_LEN          = 1
) (
  input  logic                            axis_aclk,
  input  logic                            axis_areset,
  output logic                            s0_axis_tready,
  input  logic                            s0_axis_tvalid,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s0_axis_tdata,
  input  logic                            s0_axis_tlast,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s0_axis_tstrb,
  output logic                            s1_axis_tready,
  input  logic                            s1_axis_tvalid,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s1_axis_tdata,
  input  logic                            s1_axis_tlast,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s1_axis_tstrb,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tvalid,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic                            m_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                            m_axis_tid,
  output logic [1:0]                      grant
);

  localparam int unsigned DATA_W    = C_AXIS_TDATA_WIDTH;
  localparam int unsigned STRB_W    = C_AXIS_TDATA_WIDTH / 8;
  localparam bit          BEAT_MODE = (ARB_MODE == "BEAT");
  localparam logic [7:0]  CNT_LAST  = 8'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT0 = 2'd1,
    S_GRANT1 = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_grant;
  logic                w_last_grant_nxt;
  logic [7:0]          r_cnt;
  logic [7:0]          w_cnt_nxt;

  logic                r_valid;
  logic [DATA_W-1:0]   r_data;
  logic                r_last;
  logic [STRB_W-1:0]   r_strb;
  logic                r_tid;

  logic                w_out_free;
  logic                w_hs0;
  logic                w_hs1;
  logic                w_burst_done;
  logic                w_rel0;
  logic                w_rel1;

  // Slave readies follow the output register's ability to accept a beat.
  assign w_out_free     = ~r_valid | m_axis_tready;
  assign s0_axis_tready = (r_state == S_GRANT0) & w_out_free & ~axis_areset;
  assign s1_axis_tready = (r_state == S_GRANT1) & w_out_free & ~axis_areset;
  assign w_hs0          = s0_axis_tready & s0_axis_tvalid;
  assign w_hs1          = s1_axis_tready & s1_axis_tvalid;
  assign w_burst_done   = BEAT_MODE && (r_cnt == CNT_LAST);
  assign w_rel0         = w_hs0 & (s0_axis_tlast | w_burst_done);
  assign w_rel1         = w_hs1 & (s1_axis_tlast | w_burst_done);

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_cnt        <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_cnt_nxt        = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (s0_axis_tvalid && s1_axis_tvalid) begin
          w_state_nxt = r_last_grant ? S_GRANT0 : S_GRANT1;
        end else if (s0_axis_tvalid) begin
          w_state_nxt = S_GRANT0;
        end else if (s1_axis_tvalid) begin
          w_state_nxt = S_GRANT1;
        end
      end
      S_GRANT0: begin
        if (w_rel0) begin
          w_last_grant_nxt = 1'b0;
          w_cnt_nxt        = 8'd0;
          w_state_nxt      = s1_axis_tvalid ? S_GRANT1 : S_IDLE;
        end else if (w_hs0 && BEAT_MODE) begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_GRANT1: begin
        if (w_rel1) begin
          w_last_grant_nxt = 1'b1;
          w_cnt_nxt        = 8'd0;
          w_state_nxt      = s0_axis_tvalid ? S_GRANT0 : S_IDLE;
        end else if (w_hs1 && BEAT_MODE) begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output register: load on a slave handshake, drain when downstream accepts.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_strb  <= '0;
      r_tid   <= 1'b0;
    end else if (w_hs0 || w_hs1) begin
      r_valid <= 1'b1;
      r_data  <= w_hs1 ? s1_axis_tdata : s0_axis_tdata;
      r_last  <= w_hs1 ? s1_axis_tlast : s0_axis_tlast;
      r_strb  <= w_hs1 ? s1_axis_tstrb : s0_axis_tstrb;
      r_tid   <= w_hs1;
    end else if (m_axis_tready) begin
      r_valid <= 1'b0;
    end
  end

  assign m_axis_tvalid = r_valid;
  assign m_axis_tdata  = r_data;
  assign m_axis_tlast  = r_last;
  assign m_axis_tstrb  = r_strb;
  assign m_axis_tid    = r_tid;
  assign grant         = {r_state == S_GRANT1, r_state == S_GRANT0};

endmodule

// File: tb/tb_axis_split_arbiter.sv
// Directed bench for axis_split_arbiter: a packet-mode instance driven from a
// vector table, and a beat-mode (BURST_LEN=2) instance driven by a small source model.
module tb_axis_split_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        s0_valid, s0_last, s1_valid, s1_last, m_ready;
  logic [31:0] s0_data, s1_data;
  logic [3:0]  s0_strb, s1_strb;

  logic        p_s0_ready, p_s1_ready, p_mv, p_mlast, p_tid;
  logic [31:0] p_mdata;
  logic [3:0]  p_mstrb;
  logic [1:0]  p_grant;
  logic        b_s0_ready, b_s1_ready, b_mv, b_mlast, b_tid;
  logic [31:0] b_mdata;
  logic [3:0]  b_mstrb;
  logic [1:0]  b_grant;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  axis_split_arbiter #(.C_AXIS_TDATA_WIDTH(32), .ARB_MODE("PACKET"), .BURST_LEN(1)) u_pkt (
    .axis_aclk(clk), .axis_areset(rst),
    .s0_axis_tready(p_s0_ready), .s0_axis_tvalid(s0_valid), .s0_axis_tdata(s0_data),
    .s0_axis_tlast(s0_last), .s0_axis_tstrb(s0_strb),
    .s1_axis_tready(p_s1_ready), .s1_axis_tvalid(s1_valid), .s1_axis_tdata(s1_data),
    .s1_axis_tlast(s1_last), .s1_axis_tstrb(s1_strb),
    .m_axis_tready(m_ready), .m_axis_tvalid(p_mv), .m_axis_tdata(p_mdata),
    .m_axis_tlast(p_mlast), .m_axis_tstrb(p_mstrb), .m_axis_tid(p_tid), .grant(p_grant)
  );

  axis_split_arbiter #(.C_AXIS_TDATA_WIDTH(32), .ARB_MODE("BEAT"), .BURST_LEN(2)) u_beat (
    .axis_aclk(clk), .axis_areset(rst),
    .s0_axis_tready(b_s0_ready), .s0_axis_tvalid(s0_valid), .s0_axis_tdata(s0_data),
    .s0_axis_tlast(s0_last), .s0_axis_tstrb(s0_strb),
    .s1_axis_tready(b_s1_ready), .s1_axis_tvalid(s1_valid), .s1_axis_tdata(s1_data),
    .s1_axis_tlast(s1_last), .s1_axis_tstrb(s1_strb),
    .m_axis_tready(m_ready), .m_axis_tvalid(b_mv), .m_axis_tdata(b_mdata),
    .m_axis_tlast(b_mlast), .m_axis_tstrb(b_mstrb), .m_axis_tid(b_tid), .grant(b_grant)
  );

  typedef struct {
    logic        rst;
    logic        s0v;
    logic [31:0] s0d;
    logic        s0l;
    logic        s1v;
    logic [31:0] s1d;
    logic        s1l;
    logic        mr;
    logic [1:0]  e_grant;
    logic        e_s0r;
    logic        e_s1r;
    logic        e_mv;
    logic [31:0] e_data;
    logic        e_tid;
    logic        e_last;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic a_v, input logic [31:0] a_d, input logic a_l,
                     input logic b_v, input logic [31:0] b_d, input logic b_l, input logic mr,
                     input logic [1:0] eg, input logic e0r, input logic e1r, input logic emv,
                     input logic [31:0] ed, input logic etid, input logic elast);
    vec_t v;
    v.rst = r; v.s0v = a_v; v.s0d = a_d; v.s0l = a_l;
    v.s1v = b_v; v.s1d = b_d; v.s1l = b_l; v.mr = mr;
    v.e_grant = eg; v.e_s0r = e0r; v.e_s1r = e1r; v.e_mv = emv;
    v.e_data = ed; v.e_tid = etid; v.e_last = elast;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Beat-mode expectations: tid/data/last per output beat and grant per cycle.
  logic [31:0] exp_bdata [9];
  logic        exp_btid  [9];
  logic        exp_blast [9];
  logic [1:0]  exp_bgrant[11];
  logic [31:0] got_data[$];
  logic        got_tid[$];
  logic        got_last[$];
  logic [3:0]  got_strb[$];

  initial begin
    rst = 1'b1; m_ready = 1'b1;
    s0_valid = 1'b0; s0_data = '0; s0_last = 1'b0; s0_strb = 4'hF;
    s1_valid = 1'b0; s1_data = '0; s1_last = 1'b0; s1_strb = 4'h3;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_pkt", 0, 64'({p_mv, p_mdata, p_mlast, p_mstrb, p_tid, p_grant, p_s0_ready, p_s1_ready}), 64'd0);
    chk("reset_beat", 0, 64'({b_mv, b_mdata, b_mlast, b_mstrb, b_tid, b_grant, b_s0_ready, b_s1_ready}), 64'd0);
    next_cycle();

    // Reset priority, then packet handoff A0..A2 -> B0..B2 with no bubble.
    add(1, 1, 32'hA0, 0, 1, 32'hB0, 0, 1,  2'b00, 0, 0, 0, 32'h0, 0, 0);
    add(0, 1, 32'hA0, 0, 1, 32'hB0, 0, 1,  2'b00, 0, 0, 0, 32'h0, 0, 0);
    add(0, 1, 32'hA0, 0, 1, 32'hB0, 0, 1,  2'b01, 1, 0, 0, 32'h0, 0, 0);
    add(0, 1, 32'hA1, 0, 1, 32'hB0, 0, 1,  2'b01, 1, 0, 1, 32'hA0, 0, 0);
    add(0, 1, 32'hA2, 1, 1, 32'hB0, 0, 1,  2'b01, 1, 0, 1, 32'hA1, 0, 0);
    add(0, 0, 32'h0, 0, 1, 32'hB0, 0, 1,   2'b10, 0, 1, 1, 32'hA2, 0, 1);
    add(0, 0, 32'h0, 0, 1, 32'hB1, 0, 1,   2'b10, 0, 1, 1, 32'hB0, 1, 0);
    add(0, 0, 32'h0, 0, 1, 32'hB2, 1, 1,   2'b10, 0, 1, 1, 32'hB1, 1, 0);
    add(0, 0, 32'h0, 0, 0, 32'h0, 0, 1,    2'b00, 0, 0, 1, 32'hB2, 1, 1);
    add(0, 0, 32'h0, 0, 0, 32'h0, 0, 1,    2'b00, 0, 0, 0, 32'h0, 0, 0);
    // Backpressure for 5 cycles mid-packet on s0.
    add(0, 1, 32'hC0, 0, 0, 32'h0, 0, 1,   2'b00, 0, 0, 0, 32'h0, 0, 0);
    add(0, 1, 32'hC0, 0, 0, 32'h0, 0, 1,   2'b01, 1, 0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 1, 32'hC1, 0, 0, 32'h0, 0, 0, 2'b01, 0, 0, 1, 32'hC0, 0, 0);
    add(0, 1, 32'hC1, 0, 0, 32'h0, 0, 1,   2'b01, 1, 0, 1, 32'hC0, 0, 0);
    add(0, 1, 32'hC2, 1, 0, 32'h0, 0, 1,   2'b01, 1, 0, 1, 32'hC1, 0, 0);
    add(0, 0, 32'h0, 0, 0, 32'h0, 0, 1,    2'b00, 0, 0, 1, 32'hC2, 0, 1);
    add(0, 0, 32'h0, 0, 0, 32'h0, 0, 1,    2'b00, 0, 0, 0, 32'h0, 0, 0);
    // Single requester s1 with 1-beat packets: GRANT1/IDLE alternation.
    add(0, 0, 32'h0, 0, 1, 32'hD0, 1, 1,   2'b00, 0, 0, 0, 32'h0, 0, 0);
    add(0, 0, 32'h0, 0, 1, 32'hD0, 1, 1,   2'b10, 0, 1, 0, 32'h0, 0, 0);
    add(0, 0, 32'h0, 0, 1, 32'hD1, 1, 1,   2'b00, 0, 0, 1, 32'hD0, 1, 1);
    add(0, 0, 32'h0, 0, 1, 32'hD1, 1, 1,   2'b10, 0, 1, 0, 32'h0, 0, 0);
    add(0, 0, 32'h0, 0, 1, 32'hD2, 1, 1,   2'b00, 0, 0, 1, 32'hD1, 1, 1);
    // Grant held while the granted source drops tvalid.
    add(0, 0, 32'h0, 0, 0, 32'h0, 0, 1,    2'b10, 0, 1, 0, 32'h0, 0, 0);
    add(0, 0, 32'h0, 0, 0, 32'h0, 0, 1,    2'b10, 0, 1, 0, 32'h0, 0, 0);
    // Reset in the middle of an s1 packet; s0 wins afterwards.
    add(0, 0, 32'h0, 0, 1, 32'hE0, 0, 1,   2'b10, 0, 1, 0, 32'h0, 0, 0);
    add(0, 1, 32'hF0, 0, 1, 32'hE1, 0, 1,  2'b10, 0, 1, 1, 32'hE0, 1, 0);
    add(1, 1, 32'hF0, 0, 1, 32'hE2, 0, 1,  2'b10, 0, 0, 1, 32'hE1, 1, 0);
    add(0, 1, 32'hF0, 0, 1, 32'hE2, 0, 1,  2'b00, 0, 0, 0, 32'h0, 0, 0);
    add(0, 1, 32'hF0, 0, 1, 32'hE2, 0, 1,  2'b01, 1, 0, 0, 32'h0, 0, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; m_ready = vecs[i].mr;
      s0_valid = vecs[i].s0v; s0_data = vecs[i].s0d; s0_last = vecs[i].s0l;
      s1_valid = vecs[i].s1v; s1_data = vecs[i].s1d; s1_last = vecs[i].s1l;
      @(negedge clk);
      chk("ctrl", i, 64'({p_grant, p_s0_ready, p_s1_ready, p_mv}),
          64'({vecs[i].e_grant, vecs[i].e_s0r, vecs[i].e_s1r, vecs[i].e_mv}));
      if (vecs[i].e_mv)
        chk("beat", i, 64'({p_mdata, p_tid, p_mlast, p_mstrb}),
            64'({vecs[i].e_data, vecs[i].e_tid, vecs[i].e_last, vecs[i].e_tid ? 4'h3 : 4'hF}));
      next_cycle();
    end

    // Beat mode, BURST_LEN=2: both sources always valid, s1's third beat carries tlast.
    exp_bdata = '{32'h100, 32'h101, 32'h200, 32'h201, 32'h102, 32'h103, 32'h202, 32'h104, 32'h105};
    exp_btid  = '{0, 0, 1, 1, 0, 0, 1, 0, 0};
    exp_blast = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    exp_bgrant = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
    rst = 1'b1; s0_valid = 1'b0; s1_valid = 1'b0; m_ready = 1'b1;
    next_cycle();
    rst = 1'b0;
    begin
      int n0 = 0;
      int n1 = 0;
      logic hs0, hs1;
      for (int c = 0; c < 11; c++) begin
        s0_valid = 1'b1; s0_data = 32'h100 + 32'(n0); s0_last = 1'b0;
        s1_valid = 1'b1; s1_data = 32'h200 + 32'(n1); s1_last = (n1 == 2);
        @(negedge clk);
        chk("beat_grant", c, 64'(b_grant), 64'(exp_bgrant[c]));
        if (b_mv) begin
          got_data.push_back(b_mdata); got_tid.push_back(b_tid);
          got_last.push_back(b_mlast); got_strb.push_back(b_mstrb);
        end
        hs0 = b_s0_ready & s0_valid;
        hs1 = b_s1_ready & s1_valid;
        next_cycle();
        if (hs0) n0++;
        if (hs1) n1++;
      end
    end
    chk("beat_count", 0, 64'(got_data.size()), 64'd9);
    for (int k = 0; k < 9; k++) begin
      if (k < got_data.size())
        chk("beat_out", k, 64'({got_data[k], got_tid[k], got_last[k], got_strb[k]}),
            64'({exp_bdata[k], exp_btid[k], exp_blast[k], exp_btid[k] ? 4'h3 : 4'hF}));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
